ysyx_24110006_ifu: RTL and testbench

Instruction fetch unit that consumes the single-cycle PC-valid pulse from the PC unit (`o_pc`/`o_valid`). For each pulse it issues one AXI4-Lite read (AR/R channels) at that PC. It then presents the fetched instruction, its PC and a fault flag to decode under a valid/ready handshake. It sits between the PC unit and the IDU, and is the bus master toward the MROM/flash/SRAM crossbar.

---
 rtl/ysyx_24110006_ifu_pkg.sv | 24 ++
 rtl/ysyx_24110006_ifu.sv | 134 +++++++++++++
 tb/tb_ysyx_24110006_ifu.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_24110006_ifu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_ifu_pkg
// Shared definitions for the instruction fetch unit. These are also visible
// to the PC unit:
//   - ifu_state_e : fetch FSM states (IDLE, AR, R, OUT)
//   - RESP_OKAY   : AXI OKAY response code
//   - INST_NOP    : addi x0,x0,0, presented after reset and on faults
//   - MROM_BASE / FLASH_BASE : boot memory bases shared with the PC unit
// ---------------------------------------------------------------------------
package ysyx_24110006_ifu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_OUT  = 2'd3
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam logic [31:0] INST_NOP   = 32'h0000_0013;
    localparam logic [31:0] MROM_BASE  = 32'h2000_0000;
    localparam logic [31:0] FLASH_BASE = 32'h3000_0000;

endpackage

// File: rtl/ysyx_24110006_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_24110006_ifu
// Instruction fetch unit. Each PC-valid pulse from the PC unit starts one
// AXI4-Lite read at that PC. The fetched word is then offered to the IDU
// under a valid/ready handshake.
// Ports:
//   i_clock, i_reset           clock, synchronous active-high reset
//   i_pc, i_pc_valid           fetch request pulse from the PC unit
//   o_araddr/o_arvalid/i_arready        AXI read-address channel
//   i_rdata/i_rresp/i_rvalid/o_rready   AXI read-data channel
//   o_inst, o_inst_pc, o_fault, o_valid, i_ready   output toward the IDU
//   o_busy                     FSM is not idle
//   o_lat                      AR+R cycles of the last bus fetch (saturating)
// ---------------------------------------------------------------------------
module ysyx_24110006_ifu
    import ysyx_24110006_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_INST = INST_NOP,
    parameter int          LAT_W      = 16
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [31:0]      i_pc,
    input  logic             i_pc_valid,
    output logic [31:0]      o_araddr,
    output logic             o_arvalid,
    input  logic             i_arready,
    input  logic [31:0]      i_rdata,
    input  logic [1:0]       i_rresp,
    input  logic             i_rvalid,
    output logic             o_rready,
    output logic [31:0]      o_inst,
    output logic [31:0]      o_inst_pc,
    output logic             o_fault,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy,
    output logic [LAT_W-1:0] o_lat
);

    ifu_state_e        r_state;
    logic [31:0]       r_araddr;
    logic              r_arvalid;
    logic              r_rready;
    logic [31:0]       r_inst;
    logic [31:0]       r_inst_pc;
    logic              r_fault;
    logic              r_valid;
    logic [LAT_W-1:0]  r_cnt;
    logic [LAT_W-1:0]  r_lat;

    logic [LAT_W-1:0]  w_cnt_nxt;
    logic              w_misalign;
    logic              w_rerr;

    // Saturating increment: stays at all-ones once reached.
    assign w_cnt_nxt  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
    assign w_misalign = (i_pc[1:0] != 2'b00);
    assign w_rerr     = (i_rresp != RESP_OKAY);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_araddr  <= 32'h0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_inst    <= RESET_INST;
            r_inst_pc <= 32'h0;
            r_fault   <= 1'b0;
            r_valid   <= 1'b0;
            r_cnt     <= '0;
            r_lat     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_pc_valid) begin
                        r_araddr  <= i_pc;
                        r_inst_pc <= i_pc;
                        r_cnt     <= '0;
                        if (w_misalign) begin
                            // Misaligned PC faults locally and skips the bus.
                            r_fault <= 1'b1;
                            r_inst  <= RESET_INST;
                            r_valid <= 1'b1;
                            r_state <= S_OUT;
                        end else begin
                            r_fault   <= 1'b0;
                            r_arvalid <= 1'b1;
                            r_state   <= S_AR;
                        end
                    end
                end
                S_AR: begin
                    r_cnt <= w_cnt_nxt;
                    if (r_arvalid && i_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    r_cnt <= w_cnt_nxt;
                    if (i_rvalid) begin
                        r_rready <= 1'b0;
                        r_fault  <= w_rerr;
                        r_inst   <= w_rerr ? RESET_INST : i_rdata;
                        // This cycle counts, so latch the incremented value.
                        r_lat    <= w_cnt_nxt;
                        r_valid  <= 1'b1;
                        r_state  <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (i_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_araddr  = r_araddr;
    assign o_arvalid = r_arvalid;
    assign o_rready  = r_rready;
    assign o_inst    = r_inst;
    assign o_inst_pc = r_inst_pc;
    assign o_fault   = r_fault;
    assign o_valid   = r_valid;
    assign o_busy    = (r_state != S_IDLE);
    assign o_lat     = r_lat;

endmodule

// File: tb/tb_ysyx_24110006_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24110006_ifu
// Directed bench for the fetch unit. Inputs change and outputs are sampled
// 1ns after each rising edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ysyx_24110006_ifu;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;
    logic        valid;
    logic        ready;
    logic        busy;
    logic [15:0] lat;

    int n_cmp = 0;
    int n_err = 0;
    int n_ar  = 0;
    int n_r   = 0;
    int ar0, r0;

    ysyx_24110006_ifu dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_pc      (pc),
        .i_pc_valid(pc_valid),
        .o_araddr  (araddr),
        .o_arvalid (arvalid),
        .i_arready (arready),
        .i_rdata   (rdata),
        .i_rresp   (rresp),
        .i_rvalid  (rvalid),
        .o_rready  (rready),
        .o_inst    (inst),
        .o_inst_pc (inst_pc),
        .o_fault   (fault),
        .o_valid   (valid),
        .i_ready   (ready),
        .o_busy    (busy),
        .o_lat     (lat)
    );

    always #5 clk = ~clk;

    // Handshake counters; beats seen at a reset edge are abandoned.
    always @(posedge clk) begin
        if (!rst && arvalid && arready) n_ar <= n_ar + 1;
        if (!rst && rvalid && rready)   n_r  <= n_r + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pc = '0; pc_valid = 1'b0; arready = 1'b0;
        rdata = '0; rresp = 2'b00; rvalid = 1'b0; ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_arvalid", 32'(arvalid), 0);
        chk("rst_rready",  32'(rready),  0);
        chk("rst_valid",   32'(valid),   0);
        chk("rst_fault",   32'(fault),   0);
        chk("rst_busy",    32'(busy),    0);
        chk("rst_inst",    inst,    NOP);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_araddr",  araddr,  0);
        chk("rst_lat",     32'(lat), 0);

        // ---- basic fetch, minimum latency ----
        ar0 = n_ar; r0 = n_r;
        pc = 32'h3000_0000; pc_valid = 1'b1; arready = 1'b1;
        tick();                                   // AR
        pc_valid = 1'b0;
        chk("b_arvalid", 32'(arvalid), 1);
        chk("b_araddr",  araddr, 32'h3000_0000);
        chk("b_busy",    32'(busy), 1);
        tick();                                   // R
        chk("b_arvalid_drop", 32'(arvalid), 0);
        chk("b_rready",  32'(rready), 1);
        rvalid = 1'b1; rdata = 32'h0010_0093; rresp = 2'b00; ready = 1'b1;
        tick();                                   // OUT, 3 cycles after pulse
        rvalid = 1'b0;
        chk("b_valid",   32'(valid), 1);
        chk("b_inst",    inst, 32'h0010_0093);
        chk("b_inst_pc", inst_pc, 32'h3000_0000);
        chk("b_fault",   32'(fault), 0);
        chk("b_lat",     32'(lat), 2);
        chk("b_rready_drop", 32'(rready), 0);
        tick();                                   // IDLE
        ready = 1'b0;
        chk("b_idle_valid", 32'(valid), 0);
        chk("b_idle_busy",  32'(busy), 0);
        chk("b_hs_ar", n_ar - ar0, 1);
        chk("b_hs_r",  n_r - r0, 1);

        // ---- backpressure: 5 AR cycles, 4 R cycles, 4 OUT stall cycles ----
        ar0 = n_ar; r0 = n_r;
        arready = 1'b0;
        pc = 32'h3000_0004; pc_valid = 1'b1;
        tick();                                   // AR cycle 1
        pc_valid = 1'b0; pc = 32'hFFFF_FFF0;
        for (int i = 0; i < 4; i++) begin
            chk("bp_arvalid", 32'(arvalid), 1);
            chk("bp_araddr",  araddr, 32'h3000_0004);
            tick();
        end
        arready = 1'b1;                           // AR cycle 5: handshake
        chk("bp_araddr_hs", araddr, 32'h3000_0004);
        tick();                                   // R cycle 1
        arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_rready", 32'(rready), 1);
            tick();
        end
        rvalid = 1'b1; rdata = 32'h0020_8113;     // R cycle 4: handshake
        tick();                                   // OUT
        rvalid = 1'b0; rdata = 32'h1234_5678;
        chk("bp_lat", 32'(lat), 9);
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid", 32'(valid), 1);
            chk("bp_inst",  inst, 32'h0020_8113);
            tick();
        end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("bp_idle_valid", 32'(valid), 0);
        chk("bp_hs_ar", n_ar - ar0, 1);
        chk("bp_hs_r",  n_r - r0, 1);

        // ---- misaligned PC: local fault, no bus traffic ----
        ar0 = n_ar;
        arready = 1'b1;
        pc = 32'h3000_0002; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        chk("mis_arvalid", 32'(arvalid), 0);
        chk("mis_valid",   32'(valid), 1);
        chk("mis_fault",   32'(fault), 1);
        chk("mis_inst",    inst, NOP);
        chk("mis_inst_pc", inst_pc, 32'h3000_0002);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("mis_arvalid_after", 32'(arvalid), 0);
        chk("mis_hs_ar", n_ar - ar0, 0);
        chk("mis_idle", 32'(busy), 0);

        // ---- slave error response ----
        pc = 32'h3000_0008; pc_valid = 1'b1;
        tick();                                   // AR
        pc_valid = 1'b0;
        tick();                                   // R
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b10;
        tick();                                   // OUT
        rvalid = 1'b0; rresp = 2'b00;
        chk("err_valid", 32'(valid), 1);
        chk("err_fault", 32'(fault), 1);
        chk("err_inst",  inst, NOP);
        chk("err_lat",   32'(lat), 2);
        ready = 1'b1;
        tick();
        ready = 1'b0;

        // ---- stray pulses in AR, R, OUT and at OUT handoff are ignored ----
        ar0 = n_ar; r0 = n_r;
        arready = 1'b0;
        pc = 32'h3000_000C; pc_valid = 1'b1;
        tick();                                   // AR
        pc = 32'h3000_0100;                       // pulse while in AR
        tick();
        chk("x_ar_araddr",  araddr,  32'h3000_000C);
        chk("x_ar_inst_pc", inst_pc, 32'h3000_000C);
        pc_valid = 1'b0; arready = 1'b1;
        tick();                                   // R
        arready = 1'b0;
        pc = 32'h3000_0200; pc_valid = 1'b1;      // pulse while in R
        tick();
        chk("x_r_araddr",  araddr,  32'h3000_000C);
        chk("x_r_inst_pc", inst_pc, 32'h3000_000C);
        chk("x_r_rready",  32'(rready), 1);
        pc_valid = 1'b0;
        rvalid = 1'b1; rdata = 32'h0030_0193;
        tick();                                   // OUT
        rvalid = 1'b0;
        pc = 32'h3000_0300; pc_valid = 1'b1;      // pulse while in OUT
        tick();
        chk("x_out_valid",   32'(valid), 1);
        chk("x_out_inst_pc", inst_pc, 32'h3000_000C);
        ready = 1'b1;                             // pulse coincides with handoff
        tick();
        pc_valid = 1'b0; ready = 1'b0;
        chk("x_hand_busy",    32'(busy), 0);
        chk("x_hand_valid",   32'(valid), 0);
        chk("x_hand_inst_pc", inst_pc, 32'h3000_000C);
        chk("x_hand_inst",    inst, 32'h0030_0193);
        tick(); tick();
        chk("x_quiet_arvalid", 32'(arvalid), 0);
        chk("x_quiet_busy",    32'(busy), 0);
        chk("x_hs_ar", n_ar - ar0, 1);
        chk("x_hs_r",  n_r - r0, 1);

        // ---- reset while in R with rvalid pending ----
        arready = 1'b1;
        pc = 32'h3000_0010; pc_valid = 1'b1;
        tick();                                   // AR
        pc_valid = 1'b0;
        tick();                                   // R
        arready = 1'b0;
        chk("mr_in_r", 32'(rready), 1);
        rvalid = 1'b1; rdata = 32'hCAFE_F00D; rst = 1'b1;
        tick();
        rst = 1'b0; rvalid = 1'b0;
        chk("mr_rready", 32'(rready), 0);
        chk("mr_busy",   32'(busy), 0);
        chk("mr_valid",  32'(valid), 0);
        chk("mr_inst",   inst, NOP);
        chk("mr_araddr", araddr, 0);
        chk("mr_lat",    32'(lat), 0);
        arready = 1'b1;
        pc = 32'h3000_0014; pc_valid = 1'b1;
        tick();                                   // AR
        pc_valid = 1'b0;
        chk("mr2_araddr", araddr, 32'h3000_0014);
        tick();                                   // R
        rvalid = 1'b1; rdata = 32'h0040_0213;
        tick();                                   // OUT
        rvalid = 1'b0;
        chk("mr2_valid",   32'(valid), 1);
        chk("mr2_inst",    inst, 32'h0040_0213);
        chk("mr2_inst_pc", inst_pc, 32'h3000_0014);
        chk("mr2_fault",   32'(fault), 0);
        chk("mr2_lat",     32'(lat), 2);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("mr2_idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
